jtopl_pg_ctrl: RTL and testbench
================================

// Module: jtopl_pg_ctrl
// PURPOSE
//  Slot sequencer and key-on scheduler feeding the phase generator pipeline. Walks 2*CH operator
//  slots on cenop, presents per-channel fnum/block/pms at stage I and per-slot mul/pg_rst at stage II.
//  Holds the channel/operator register file written by the CPU interface; turns key-on rising
//  edges into exactly one phase reset per operator, scheduled on that operator's next slot.
// PARAMETERS
//  CH   9   channels; slots = 2*CH (1..16 allowed); slot s: ch = s % CH, op = s / CH (0=mod,1=car)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active high
//  cenop      in   1   operator clock enable; all state advances only when high
//  ch_we      in   1   channel register write strobe (single clk, independent of cenop)
//  ch_sel     in   4   channel written (values >= CH ignored)
//  ch_fnum    in  10   F-number
//  ch_block   in   3   octave block
//  ch_pms     in   3   vibrato depth select
//  ch_kon     in   1   key state for channel
//  op_we      in   1   operator register write strobe
//  op_sel     in   5   slot written (values >= 2*CH ignored)
//  op_mul     in   4   frequency multiplier
//  csm_trig   in   1   composite-sine key-on pulse (used only with JTOPL_PG_CSM_EN)
//  slot_I     out  5   slot currently at stage I
//  zero       out  1   high while slot_I == 0
//  fnum_I     out 10   fnum of ch(slot_I)
//  block_I    out  3   block of ch(slot_I)
//  pms_I      out  3   pms of ch(slot_I)
//  mul_II     out  4   mul of slot at stage II (slot_I of previous cenop)
//  pg_rst_II  out  1   phase reset for slot at stage II
//  kon_II     out  1   key state of ch(stage II slot), for envelope generator
// BEHAVIOUR
//  Reset: slot_I=0, zero=1, all outputs 0, register file cleared, all pending flags clear.
//  Sequencing (cenop=1): slot_I <= slot_I==2*CH-1 ? 0 : slot_I+1; stage I outputs loaded from the
//   register file for the slot being entered; stage II outputs take the slot leaving stage I.
//   Outputs registered; latency stage I->II = exactly one cenop. cenop=0: all outputs hold.
//  Writes: take effect on clk edge regardless of cenop. Write to a channel/slot loaded by the same
//   cenop edge: old value is presented; new value appears from next pass. Same-cycle ch_we/op_we ok.
//  Key-on scheduling: pend[2*CH] flags. ch_we with ch_kon=1 while stored kon=0 (rising edge) sets
//   pend for both slots of that channel. ch_we with ch_kon=0 clears stored kon and both pend flags.
//   kon=1 rewrite while already on: no new pend.
//  Issue: when slot s moves to stage II, pg_rst_II <= pend[s]; pend[s] cleared same edge.
//  Collision: rising edge on same edge as pend[s] clear -> set wins; pg_rst_II still issued now and
//   pend[s] stays set, so reset repeats on next pass. Key-off same edge as issue -> pg_rst_II=0.
//  kon_II reflects stored kon sampled when slot entered stage II (not the write-cycle value).
//  Mid-operation rst: sequence restarts at slot 0 next cycle; pending resets discarded.
// CONFIGURATION
//  JTOPL_PG_CSM_EN defined: csm_trig pulse (clk-level) sets pend for all 2*CH slots as a forced
//   key-on, without altering stored kon; combined with ch_we key-off same edge, key-off wins for
//   that channel only. Undefined: csm_trig ignored, no CSM logic synthesized.
// TESTING
//  1 rst 3 clk, cenop=1 -> slot_I 0,1..17,0 with zero high only at slot_I=0; outputs 0 after rst.
//  2 ch_we ch3 fnum=0x2A5 block=5; op_we slot12 mul=7 -> fnum_I=0x2A5,block_I=5 at slot_I=3,12;
//    mul_II=7 one cenop after slot_I=12, 0 elsewhere.
//  3 key-on ch3 (kon 0->1) at slot_I=0 -> pg_rst_II=1 exactly at stage II slots 3 and 12, then
//    never again over 3 passes; kon_II=1 from slot 3 on.
//  4 key-on ch0 on edge where slot 0 issues -> pg_rst_II=1 that cycle and again next pass slot 0.
//  5 key-on ch5 then key-off before slot 5 -> no pg_rst_II; kon_II=0; cenop held low 10 clk -> hold.
//  6 JTOPL_PG_CSM_EN: csm_trig at slot_I=7 -> pg_rst_II on all 18 slots over next pass, once each;
//    macro off -> none.

Source files
------------

// File: rtl/jtopl_pg_ctrl.sv
// jtopl_pg_ctrl: slot sequencer and key-on phase-reset scheduler for the phase generator
// Ports: clk, rst (sync, active high), cenop (operator enable);
//   ch_we/ch_sel/ch_fnum/ch_block/ch_pms/ch_kon channel writes; op_we/op_sel/op_mul slot writes;
//   csm_trig forced key-on of all slots, active only with JTOPL_PG_CSM_EN defined;
//   stage I: slot_I, zero, fnum_I, block_I, pms_I; stage II: mul_II, pg_rst_II, kon_II.
module jtopl_pg_ctrl #(
  parameter int CH = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cenop,
  input  logic       ch_we,
  input  logic [3:0] ch_sel,
  input  logic [9:0] ch_fnum,
  input  logic [2:0] ch_block,
  input  logic [2:0] ch_pms,
  input  logic       ch_kon,
  input  logic       op_we,
  input  logic [4:0] op_sel,
  input  logic [3:0] op_mul,
  input  logic       csm_trig,
  output logic [4:0] slot_I,
  output logic       zero,
  output logic [9:0] fnum_I,
  output logic [2:0] block_I,
  output logic [2:0] pms_I,
  output logic [3:0] mul_II,
  output logic       pg_rst_II,
  output logic       kon_II
);
  localparam int SL = 2 * CH;
  localparam int CW = CH > 1 ? $clog2(CH) : 1;
  logic [9:0] fnum [CH];
  logic [2:0] block [CH];
  logic [2:0] pms [CH];
  logic [3:0] mul [SL];
  logic [CH-1:0] kon, rise, off;
  logic [SL-1:0] pend, set, pend_nx;
  logic [4:0] slot_nx;
  logic [CW-1:0] ch_cur, ch_nx, ch_w;
  logic ch_ok, op_ok, csm;
  function automatic logic [CW-1:0] ch_of(input logic [4:0] s);
    return CW'(s >= 5'(CH) ? s - 5'(CH) : s);
  endfunction
`ifdef JTOPL_PG_CSM_EN
  assign csm = csm_trig;
`else
  logic unused_csm;
  assign unused_csm = csm_trig;
  assign csm = 1'b0;
`endif
  assign ch_ok = ch_we && int'(ch_sel) < CH;
  assign op_ok = op_we && int'(op_sel) < SL;
  assign ch_w = CW'(ch_sel);
  assign slot_nx = slot_I == 5'(SL - 1) ? 5'd0 : slot_I + 5'd1;
  assign ch_cur = ch_of(slot_I);
  assign ch_nx = ch_of(slot_nx);
  // A key-on set beats the issue clear, so a collision re-issues on the next pass;
  // a key-off always clears both slots of its channel.
  always_comb begin
    rise = '0;
    off = '0;
    set = '0;
    pend_nx = '0;
    for (int c = 0; c < CH; c++) begin
      rise[c] = ch_ok && ch_w == CW'(c) && ch_kon && !kon[c];
      off[c] = ch_ok && ch_w == CW'(c) && !ch_kon;
    end
    for (int s = 0; s < SL; s++) begin
      set[s] = rise[s % CH] || (csm && !off[s % CH]);
      pend_nx[s] = set[s] || (pend[s] && !off[s % CH] && !(cenop && slot_I == 5'(s)));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_I <= '0;
      zero <= 1'b1;
      fnum_I <= '0;
      block_I <= '0;
      pms_I <= '0;
      mul_II <= '0;
      pg_rst_II <= 1'b0;
      kon_II <= 1'b0;
      kon <= '0;
      pend <= '0;
      for (int c = 0; c < CH; c++) begin
        fnum[c] <= '0;
        block[c] <= '0;
        pms[c] <= '0;
      end
      for (int s = 0; s < SL; s++) mul[s] <= '0;
    end else begin
      pend <= pend_nx;
      if (ch_ok) begin
        fnum[ch_w] <= ch_fnum;
        block[ch_w] <= ch_block;
        pms[ch_w] <= ch_pms;
        kon[ch_w] <= ch_kon;
      end
      if (op_ok) mul[op_sel] <= op_mul;
      if (cenop) begin
        slot_I <= slot_nx;
        zero <= slot_nx == 5'd0;
        fnum_I <= fnum[ch_nx];
        block_I <= block[ch_nx];
        pms_I <= pms[ch_nx];
        mul_II <= mul[slot_I];
        pg_rst_II <= (pend[slot_I] || set[slot_I]) && !off[ch_cur];
        kon_II <= kon[ch_cur];
      end
    end
  end
endmodule

// File: tb/tb_jtopl_pg_ctrl.sv
// tb_jtopl_pg_ctrl: scoreboard bench for the slot sequencer and key-on scheduler
module tb_jtopl_pg_ctrl;
  logic clk = 0, rst = 1, cenop = 0, ch_we = 0, ch_kon = 0, op_we = 0, csm_trig = 0;
  logic [3:0] ch_sel = 0, op_mul = 0;
  logic [9:0] ch_fnum = 0;
  logic [2:0] ch_block = 0, ch_pms = 0;
  logic [4:0] op_sel = 0;
  logic [4:0] slot_I;
  logic zero, pg_rst_II, kon_II;
  logic [9:0] fnum_I;
  logic [2:0] block_I, pms_I;
  logic [3:0] mul_II;
  typedef struct {
    int slot;
    int zero;
    int fnum;
    int block;
    int pms;
    int mul;
    int pgr;
    int kon;
  } exp_t;
  exp_t sb[$];
  exp_t last;
  int m_fnum[9], m_block[9], m_pms[9], m_mul[18];
  bit m_kon[9], m_pend[18];
  int m_slot;
  int n_chk = 0, n_fail = 0, pulses = 0;
  jtopl_pg_ctrl #(.CH(9)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .ch_we(ch_we), .ch_sel(ch_sel), .ch_fnum(ch_fnum),
    .ch_block(ch_block), .ch_pms(ch_pms), .ch_kon(ch_kon), .op_we(op_we), .op_sel(op_sel),
    .op_mul(op_mul), .csm_trig(csm_trig), .slot_I(slot_I), .zero(zero), .fnum_I(fnum_I),
    .block_I(block_I), .pms_I(pms_I), .mul_II(mul_II), .pg_rst_II(pg_rst_II), .kon_II(kon_II)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wr(input int c, input int f, input int b, input int p, input bit k);
    ch_we = 1;
    ch_sel = 4'(c);
    ch_fnum = 10'(f);
    ch_block = 3'(b);
    ch_pms = 3'(p);
    ch_kon = k;
  endtask
  // Predict the outputs after the coming edge from the bench's own model, then advance it.
  task automatic step(input bit cen);
    exp_t e;
    int cur, nx, cc, c;
    bit hit, rise, off, csm_on, setv, clr;
    cenop = cen;
`ifdef JTOPL_PG_CSM_EN
    csm_on = csm_trig;
`else
    csm_on = 0;
`endif
    e = last;
    cur = m_slot;
    nx = cur == 17 ? 0 : cur + 1;
    cc = cur % 9;
    c = int'(ch_sel);
    hit = ch_we && c < 9;
    rise = hit && ch_kon && !m_kon[c];
    off = hit && !ch_kon;
    if (cen) begin
      e.slot = nx;
      e.zero = nx == 0;
      e.fnum = m_fnum[nx % 9];
      e.block = m_block[nx % 9];
      e.pms = m_pms[nx % 9];
      e.mul = m_mul[cur];
      e.kon = m_kon[cc];
      setv = (rise && c == cc) || (csm_on && !(off && c == cc));
      e.pgr = (m_pend[cur] || setv) && !(off && c == cc);
    end
    sb.push_back(e);
    last = e;
    for (int s = 0; s < 18; s++) begin
      setv = (rise && c == s % 9) || (csm_on && !(off && c == s % 9));
      clr = (off && c == s % 9) || (cen && s == cur);
      m_pend[s] = setv ? 1'b1 : clr ? 1'b0 : m_pend[s];
    end
    if (hit) begin
      m_fnum[c] = int'(ch_fnum);
      m_block[c] = int'(ch_block);
      m_pms[c] = int'(ch_pms);
      m_kon[c] = ch_kon;
    end
    if (op_we && op_sel < 18) m_mul[op_sel] = int'(op_mul);
    if (cen) m_slot = nx;
    @(posedge clk);
    #1;
    ch_we = 0;
    op_we = 0;
    csm_trig = 0;
    e = sb.pop_front();
    chk("slot_I", 32'(slot_I), e.slot);
    chk("zero", 32'(zero), e.zero);
    chk("fnum_I", 32'(fnum_I), e.fnum);
    chk("block_I", 32'(block_I), e.block);
    chk("pms_I", 32'(pms_I), e.pms);
    chk("mul_II", 32'(mul_II), e.mul);
    chk("pg_rst_II", 32'(pg_rst_II), e.pgr);
    chk("kon_II", 32'(kon_II), e.kon);
    pulses += int'(pg_rst_II);
  endtask
  task automatic run(input int n);
    repeat (n) step(1);
  endtask
  task automatic goto_slot(input int s);
    repeat (18) if (m_slot != s) step(1);
  endtask
  initial begin
    cenop = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    cenop = 0;
    for (int i = 0; i < 9; i++) begin
      m_fnum[i] = 0; m_block[i] = 0; m_pms[i] = 0; m_kon[i] = 0;
    end
    for (int i = 0; i < 18; i++) begin
      m_mul[i] = 0; m_pend[i] = 0;
    end
    m_slot = 0;
    last = '{0, 1, 0, 0, 0, 0, 0, 0};
    chk("rst_slot", 32'(slot_I), 0);
    chk("rst_zero", 32'(zero), 1);
    chk("rst_fnum", 32'(fnum_I), 0);
    chk("rst_mul", 32'(mul_II), 0);
    chk("rst_pgrst", 32'(pg_rst_II), 0);
    chk("rst_kon", 32'(kon_II), 0);
    run(19);
    chk("t1_wrap", 32'(slot_I), 1);
    wr(3, 'h2A5, 5, 2, 0);
    op_we = 1;
    op_sel = 12;
    op_mul = 7;
    step(1);
    wr(12, 'h3FF, 7, 7, 1);
    step(1);
    run(18);
    goto_slot(0);
    wr(3, 'h2A5, 5, 2, 1);
    pulses = 0;
    step(1);
    run(53);
    chk("t3_pulses", pulses, 2);
    goto_slot(0);
    wr(0, 'h100, 2, 1, 1);
    pulses = 0;
    step(1);
    chk("t4_issue_now", 32'(pg_rst_II), 1);
    run(35);
    chk("t4_pulses", pulses, 3);
    goto_slot(1);
    wr(5, 'h155, 3, 4, 1);
    step(1);
    wr(5, 'h155, 3, 4, 0);
    pulses = 0;
    step(1);
    run(36);
    chk("t5_pulses", pulses, 0);
    repeat (10) step(0);
    run(2);
    goto_slot(7);
    csm_trig = 1;
    pulses = 0;
    step(1);
    run(17);
`ifdef JTOPL_PG_CSM_EN
    chk("t6_csm_pulses", pulses, 18);
`else
    chk("t6_csm_pulses", pulses, 0);
`endif
    run(18);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
